// File: rtl/elastic_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// elastic_buffer_ctrl
//
// Read-domain controller for an elastic (clock-compensation) buffer. The write
// pointer arrives as Gray code from the write clock domain. It is synchronised,
// converted to binary and subtracted from the read pointer to produce a
// registered fill level. A small FSM uses that fill level to do three things:
// gate the read pointer, ask the read-pointer logic to repeat a SKP symbol when
// the buffer runs low, and ask it to drop a SKP symbol when the buffer runs
// high.
//
// Request semantics: add_req / del_req are level requests. Each one stays high
// for as long as the FSM is in ADD / DEL. ADD is acknowledged by skp_added.
// DEL is acknowledged by a SKP symbol on data_out while read_enable is high.
// A request that is not acknowledged is withdrawn after TIMEOUT cycles. The two
// requests are mutually exclusive because each one is decoded from its own
// state.
//
// Optional feature: define ELASTIC_BUF_STATS_EN to add the saturating
// add_count / del_count / err_count statistics outputs.
//
// Ports
//   read_clk            in   read-domain clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   gray_write_pointer  in   [AW:0] Gray write pointer (unsynchronised)
//   read_address        in   [AW:0] binary read pointer
//   data_out            in   [DATA_WIDTH-1:0] symbol at the buffer output
//   skp_added           in   read-pointer logic repeated a SKP this cycle
//   buffer_mode         in   1 = nominal half full, 0 = nominal empty
//   read_enable         out  read pointer may advance
//   add_req             out  request SKP insertion
//   del_req             out  request SKP deletion
//   fill_level          out  [AW:0] registered occupancy
//   underflow           out  single-cycle pulse, buffer ran dry while reading
//   overflow            out  single-cycle pulse, occupancy reached BUFFER_DEPTH
//   state               out  [1:0] FSM state (FILL=0, RUN=1, ADD=2, DEL=3)
//   add_count           out  [15:0] completed insertions   (stats build only)
//   del_count           out  [15:0] completed deletions    (stats build only)
//   err_count           out  [15:0] underflow/overflow/timeout events (stats)
// -----------------------------------------------------------------------------
module elastic_buffer_ctrl #(
  parameter int DATA_WIDTH   = 10,
  parameter int BUFFER_DEPTH = 16,
  parameter int HI_WM        = 12,
  parameter int LO_WM        = 4,
  parameter int TIMEOUT      = 255,
  localparam int AW          = $clog2(BUFFER_DEPTH)
) (
  input  logic                  read_clk,
  input  logic                  rst_n,
  input  logic [AW:0]           gray_write_pointer,
  input  logic [AW:0]           read_address,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  skp_added,
  input  logic                  buffer_mode,
  output logic                  read_enable,
  output logic                  add_req,
  output logic                  del_req,
  output logic [AW:0]           fill_level,
  output logic                  underflow,
  output logic                  overflow,
  output logic [1:0]            state
`ifdef ELASTIC_BUF_STATS_EN
  ,
  output logic [15:0]           add_count,
  output logic [15:0]           del_count,
  output logic [15:0]           err_count
`endif
);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_DEL  = 2'd3;

  // Thresholds cast to the fill-level width so that the comparisons stay
  // width-matched.
  localparam logic [AW:0] L_HALF  = (AW+1)'(BUFFER_DEPTH / 2);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(BUFFER_DEPTH);
  localparam logic [AW:0] L_HI    = (AW+1)'(HI_WM);
  localparam logic [AW:0] L_LO    = (AW+1)'(LO_WM);
  localparam logic [7:0]  L_TMO   = 8'(TIMEOUT);

  localparam logic [DATA_WIDTH-1:0] SKP_POS = DATA_WIDTH'(10'b0011111001);
  localparam logic [DATA_WIDTH-1:0] SKP_NEG = DATA_WIDTH'(10'b1100000110);

  logic [AW:0] r_sync1;
  logic [AW:0] r_sync2;
  logic [AW:0] r_fill;
  logic [AW:0] w_wr_bin;
  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [7:0]  r_timer;
  logic        r_ovf_cond_d;
  logic        w_ovf_cond;
  logic        w_underflow;
  logic        w_overflow;
  logic        w_is_skp;
  logic        w_timed_out;
  logic        w_restart;
  logic        w_add_done;
  logic        w_del_done;
  logic        w_timeout;
  logic        w_next_is_req;
  logic        w_read_en;

  // Two-flop synchroniser for the Gray write pointer.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gray_write_pointer;
      r_sync2 <= r_sync1;
    end
  end

  // Gray to binary: bit i is the XOR of all Gray bits from i upwards.
  always_comb begin
    w_wr_bin = '0;
    for (int i = 0; i <= AW; i++) begin
      w_wr_bin[i] = ^(r_sync2 >> i);
    end
  end

  // The modulo-2^(AW+1) subtraction already handles pointer wrap.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else begin
      r_fill <= w_wr_bin - read_address;
    end
  end

  assign w_read_en   = (r_state != ST_FILL);
  assign w_is_skp    = (data_out == SKP_POS) || (data_out == SKP_NEG);
  assign w_timed_out = (r_timer == L_TMO);
  assign w_underflow = w_read_en && (r_fill == '0);

  // Overflow is edge-detected so that a buffer that stays full reports a
  // single event and does not keep restarting the DEL timeout.
  assign w_ovf_cond  = (r_fill >= L_DEPTH);
  assign w_overflow  = w_ovf_cond && !r_ovf_cond_d;

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cond_d <= 1'b0;
    end else begin
      r_ovf_cond_d <= w_ovf_cond;
    end
  end

  // Next-state logic. Underflow beats every other transition. Overflow comes
  // next and forces DEL, or restarts DEL if the FSM is already there.
  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_add_done   = 1'b0;
    w_del_done   = 1'b0;
    w_timeout    = 1'b0;
    if (w_underflow) begin
      w_next_state = ST_FILL;
    end else if (w_overflow) begin
      w_next_state = ST_DEL;
      w_restart    = 1'b1;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (buffer_mode ? (r_fill >= L_HALF) : (r_fill != '0)) begin
            w_next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (buffer_mode && (r_fill <= L_LO)) begin
            w_next_state = ST_ADD;
            w_restart    = 1'b1;
          end else if (r_fill >= L_HI) begin
            w_next_state = ST_DEL;
            w_restart    = 1'b1;
          end
        end
        ST_ADD: begin
          if (skp_added) begin
            w_next_state = ST_RUN;
            w_add_done   = 1'b1;
          end else if (w_timed_out) begin
            w_next_state = ST_RUN;
            w_timeout    = 1'b1;
          end
        end
        default: begin
          if (w_is_skp && w_read_en) begin
            w_next_state = ST_RUN;
            w_del_done   = 1'b1;
          end else if (w_timed_out) begin
            w_next_state = ST_RUN;
            w_timeout    = 1'b1;
          end
        end
      endcase
    end
  end

  assign w_next_is_req = (w_next_state == ST_ADD) || (w_next_state == ST_DEL);

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Timeout counter: zero outside ADD/DEL and on entry, then counts every
  // cycle spent waiting. It holds at its maximum value instead of wrapping.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_restart || !w_next_is_req) begin
      r_timer <= '0;
    end else if (r_timer != 8'hFF) begin
      r_timer <= r_timer + 8'd1;
    end
  end

  assign state       = r_state;
  assign read_enable = w_read_en;
  assign add_req     = (r_state == ST_ADD);
  assign del_req     = (r_state == ST_DEL);
  assign fill_level  = r_fill;
  assign underflow   = w_underflow;
  assign overflow    = w_overflow;

`ifdef ELASTIC_BUF_STATS_EN
  logic [15:0] r_add_count;
  logic [15:0] r_del_count;
  logic [15:0] r_err_count;

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_add_count <= '0;
      r_del_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_add_done && (r_add_count != 16'hFFFF)) begin
        r_add_count <= r_add_count + 16'd1;
      end
      if (w_del_done && (r_del_count != 16'hFFFF)) begin
        r_del_count <= r_del_count + 16'd1;
      end
      if ((w_underflow || w_overflow || w_timeout) && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign add_count = r_add_count;
  assign del_count = r_del_count;
  assign err_count = r_err_count;
`endif

endmodule
